// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_e        : loader FSM states
//   LEN_W          : width of the big-endian word-count field
//   BYTES_PER_WORD : stream bytes assembled into one instruction word
package loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    WORD,
    CHECK,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler for the program loader.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : restart assembly at byte 0 (has priority over shift_i)
//   shift_i      : shift byte_i in as the newest (least significant) byte
//   byte_i       : stream byte
//   word_o       : word formed by the three held bytes plus byte_i
//   word_full_o  : high in the cycle the 4th byte of a word is shifted in
// word_o/word_full_o look at the byte being shifted this cycle, so the
// parent can register the complete word on the same edge that accepts
// its last byte. That keeps the stream free of bubbles.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [23:0] shreg_q, shreg_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (clr_i) begin
      shreg_d = '0;
      idx_d   = '0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[15:0], byte_i};
      idx_d   = idx_q + 2'd1;   // wraps mod 4
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o      = {shreg_q, byte_i};
  assign word_full_o = shift_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes 32-bit words into instruction memory
// while holding the core stopped, then releases it.
// Stream: N (16-bit BE), 4*N payload bytes (BE words), XOR checksum byte.
//   clk, rst          : clock, synchronous active-high reset
//   start             : begin a load (sampled only in IDLE)
//   byte_valid/_data  : source byte; transfer on byte_valid & byte_ready
//   byte_ready        : loader accepts a byte
//   im_wren/addr/data : registered instruction-memory write port
//   cpu_hold          : keeps the core stopped while high
//   busy              : high outside IDLE
//   done              : one-cycle pulse on successful completion
//   err               : sticky error, cleared by the next start or rst
module prog_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_wren,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One bit wider than the length field so 2^ADDR_W itself is representable.
  localparam logic [LEN_W:0] CAPACITY = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

  state_e             state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  widx_q, widx_d;
  logic [7:0]         csum_q, csum_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               hold_q, hold_d;
  logic               wren_q, wren_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        data_q, data_d;

  logic               accept;
  logic [LEN_W-1:0]   len_full;
  logic               last_word;
  logic               packer_clr;
  logic               packer_shift;
  logic [31:0]        packed_word;
  logic               word_full;

  assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                      (state_q == WORD)   || (state_q == CHECK);
  assign busy       = (state_q != IDLE);
  assign accept     = byte_valid && byte_ready;
  assign len_full   = {len_hi_q, byte_data};
  // In WORD the count is at least 1 and at most 2^ADDR_W, so len_q-1 fits.
  assign last_word  = (LEN_W'(widx_q) == (len_q - LEN_W'(1)));

  assign packer_clr   = (state_q == LEN_LO) && accept;
  assign packer_shift = (state_q == WORD) && accept;

  byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (packer_clr),
    .shift_i     (packer_shift),
    .byte_i      (byte_data),
    .word_o      (packed_word),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    widx_d   = widx_q;
    csum_d   = csum_q;
    err_d    = err_q;
    done_d   = 1'b0;
    hold_d   = hold_q;
    wren_d   = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          csum_d  = '0;
          hold_d  = 1'b1;
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_hi_d = byte_data;
          csum_d   = csum_q ^ byte_data;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d  = len_full;
          csum_d = csum_q ^ byte_data;
          widx_d = '0;
          if ({1'b0, len_full} > CAPACITY) begin
            err_d   = 1'b1;   // raised on entry so it is visible during ERR
            state_d = ERR;
          end else if (len_full == '0) begin
            state_d = CHECK;
          end else begin
            state_d = WORD;
          end
        end
      end
      WORD: begin
        if (accept) begin
          csum_d = csum_q ^ byte_data;
          if (word_full) begin
            wren_d = 1'b1;
            addr_d = widx_q;
            data_d = packed_word;
            widx_d = widx_q + ADDR_W'(1);   // wraps to 0 after a full fill
            if (last_word) begin
              state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (byte_data == csum_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_hi_q <= '0;
      len_q    <= '0;
      widx_q   <= '0;
      csum_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= HOLD_AT_RESET;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      widx_q   <= widx_d;
      csum_q   <= csum_d;
      err_q    <= err_d;
      done_q   <= done_d;
      hold_q   <= hold_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign im_wren  = wren_q;
  assign im_addr  = addr_q;
  assign im_data  = data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes 32-bit instructions into instruction memory while holding the single-cycle core stopped, then releases it. It is the write side of the instruction-memory interface that the core's fetch path reads from. It sits between an external byte source (UART receiver, test harness) and the instruction memory write port. It drives the core's PC enable through `cpu_hold`.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `HOLD_AT_RESET`, default 1: reset value of `cpu_hold`.
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begins a load; sampled only in IDLE.
- `byte_valid`  in  1  source has a byte.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte; transfer occurs when `byte_valid & byte_ready`.
- `im_wren`  out  1  instruction-memory write strobe, one cycle per word.
- `im_addr`  out  ADDR_W  word address, word-addressed, base 0.
- `im_data`  out  32  word to write.
- `cpu_hold`  out  1  high keeps the core stopped (PCEn = ~cpu_hold).
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error flag.

## Operation
- Stream format, in order:
  - 2-byte word count N, big-endian.
  - 4N payload bytes; each word is big-endian (first byte becomes `im_data[31:24]`).
  - 1 checksum byte: XOR of every preceding byte, including the length bytes.
- States:
  - IDLE: if `start`, clear `err`, clear checksum accumulator, set `cpu_hold`=1, go to LEN_HI.
  - LEN_HI: on accept, latch N[15:8], go to LEN_LO.
  - LEN_LO: on accept, latch N[7:0].
    - If N > 2^ADDR_W, go to ERR.
    - If N = 0, go to CHECK.
    - Otherwise go to WORD with byte index 0 and word index 0.
  - WORD: on accept, shift the byte into the assembly register and increment the byte index mod 4.
    - On byte index 3: write the word at the current word index and increment the word index.
    - If that was the last word, go to CHECK.
  - CHECK: on accept, compare the received byte with the accumulator.
    - Match: go to DONE.
    - Mismatch: go to ERR.
  - DONE: pulse `done`, set `cpu_hold`=0, go to IDLE.
  - ERR: set `err`=1, keep `cpu_hold`=1, go to IDLE. `err` stays high until the next `start` or `rst`.
- `byte_ready` is 1 in LEN_HI, LEN_LO, WORD and CHECK; 0 in IDLE, DONE and ERR.
- The checksum accumulator XORs every accepted byte except the checksum byte itself.
- `start` outside IDLE is ignored.
- `byte_valid` in IDLE is ignored; no byte is consumed.

## Timing
- Reset values:
  - State = IDLE.
  - `cpu_hold` = HOLD_AT_RESET.
  - `byte_ready`, `im_wren`, `done`, `err`, `busy` = 0.
  - `im_addr` = 0, `im_data` = 0.
- Write latency: `im_wren`, `im_addr` and `im_data` are registered. They are valid for exactly one cycle, the cycle after the 4th byte of a word is accepted.
- `im_addr`/`im_data` hold their last values when `im_wren`=0.
- Throughput is one byte per cycle with no bubbles. `byte_ready` stays high across word boundaries, so the next byte is accepted in the same cycle as the write.
- After the checksum byte is accepted, `done` (or `err` rising) appears one cycle later, in the same cycle `cpu_hold` falls (or stays high). Flags are registered.
- N = 2^ADDR_W is legal and fills memory. The final word goes to address 2^ADDR_W−1, and the word index wraps to 0 without a further write.
- `rst` mid-load: IDLE next cycle, all outputs return to reset values, and partial writes already made remain in memory.
- A stalled source (`byte_valid`=0) holds state indefinitely; there is no timeout.

## Structure
- Package `loader_pkg`:
  - State enum (IDLE, LEN_HI, LEN_LO, WORD, CHECK, DONE, ERR).
  - Length field width 16.
  - Bytes-per-word constant 4.
- Sub-module `byte_packer`:
  - 4-byte big-endian shift register and 2-bit byte index.
  - Outputs `word_full` for one cycle when the 4th byte has been shifted in.
  - The FSM drives its clear and shift-enable.

## Test plan
- Basic load: N=2, words 0x20080005 and 0xAC080000, checksum 0x00^0x02^(all 8 payload bytes). Expect exactly two `im_wren` pulses: addr 0 / 0x20080005, then addr 1 / 0xAC080000. Then `done` for 1 cycle and `cpu_hold` 1→0.
- Bad checksum: same stream with checksum byte XOR 0x01. Expect both writes to occur, then `err`=1, `cpu_hold` stays 1, `done` never pulses. A new `start` clears `err`.
- Empty and overflow lengths:
  - N=0 with checksum 0x00: `done` with zero writes.
  - N=0x0101 with ADDR_W=8: `err` after LEN_LO, `byte_ready`=0 from then on, no writes.
- Backpressure and throughput: randomly gate `byte_valid` for a 4-word load and check that data and addresses are unchanged. With `byte_valid` held high, consecutive writes are exactly 4 cycles apart.
- Reset and control corner cases:
  - Assert `rst` after 6 bytes of a 3-word load: next cycle everything is at reset values and `cpu_hold` = HOLD_AT_RESET.
  - A following complete load succeeds.
  - `start` pulsed mid-load has no effect.
